// File: rtl/z80_screen_read_responder.sv
// Z80 read responder for the screen RAM window: synchronises the Z80 strobes, fetches the
// addressed byte from the shared screen memory and drives it onto the data bus while /RD is held.
module z80_screen_read_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] BASE_ADDR   = 16'h4000,
    parameter logic [15:0] TOP_ADDR    = 16'h5AFF,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] A,
    input  logic        MREQ,
    input  logic        RD,
    input  logic        IORQ,
    input  logic        M1,
    output logic [12:0] MEM_ADDR,
    output logic        MEM_RE,
    input  logic [7:0]  MEM_DATA,
    output logic [7:0]  D_OUT,
    output logic        D_DRIVE,
    output logic [15:0] HIT_COUNT
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DRIVE} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_mreq_sync;
    logic [SYNC_STAGES-1:0] r_rd_sync;
    logic [SYNC_STAGES-1:0] r_iorq_sync;
    logic [SYNC_STAGES-1:0] r_m1_sync;
    logic [15:0]            r_a_sync [SYNC_STAGES];
    logic                   r_rd_req_q;
    logic                   r_abort;
    logic                   r_drive_q;
    logic [1:0]             r_lat_cnt;
    logic [12:0]            r_mem_addr;
    logic                   r_mem_re;
    logic [7:0]             r_d_out;
    logic [15:0]            r_hit_count;

    logic [15:0] w_a_s;
    logic        w_rd_req;
    logic        w_req_edge;
    logic        w_in_window;
    logic        w_lat_done;
    logic        w_start;
    logic        w_capture;
    logic        w_drive_nxt;
    logic        w_hit_inc;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_mreq_sync <= '1;
            r_rd_sync   <= '1;
            r_iorq_sync <= '1;
            r_m1_sync   <= '1;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) r_a_sync[i] <= '0;
        end else begin
            r_mreq_sync <= {r_mreq_sync[SYNC_STAGES-2:0], MREQ};
            r_rd_sync   <= {r_rd_sync[SYNC_STAGES-2:0], RD};
            r_iorq_sync <= {r_iorq_sync[SYNC_STAGES-2:0], IORQ};
            r_m1_sync   <= {r_m1_sync[SYNC_STAGES-2:0], M1};
            r_a_sync[0] <= A;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) r_a_sync[i] <= r_a_sync[i-1];
        end
    end

    // Interrupt acknowledge (/M1 & /IORQ) is excluded explicitly, not only via the IORQ term.
    assign w_a_s       = r_a_sync[SYNC_STAGES-1];
    assign w_rd_req    = ~r_mreq_sync[SYNC_STAGES-1] & ~r_rd_sync[SYNC_STAGES-1]
                       & r_iorq_sync[SYNC_STAGES-1]
                       & ~(~r_m1_sync[SYNC_STAGES-1] & ~r_iorq_sync[SYNC_STAGES-1]);
    assign w_req_edge  = w_rd_req & ~r_rd_req_q;
    assign w_in_window = (w_a_s >= BASE_ADDR) && (w_a_s <= TOP_ADDR);
    assign w_lat_done  = (r_lat_cnt == 2'(RAM_LATENCY - 1));

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_FETCH;
            S_FETCH: if (w_lat_done) w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = w_capture ? S_DRIVE : S_IDLE;
            S_DRIVE: if (!w_rd_req) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_start     = (r_state == S_IDLE) && w_req_edge && w_in_window;
        w_capture   = (r_state == S_WAIT) && !r_abort && w_rd_req;
        w_drive_nxt = w_capture || ((r_state == S_DRIVE) && w_rd_req);
        w_hit_inc   = (r_state == S_DRIVE) && !w_rd_req;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rd_req_q  <= 1'b0;
            r_abort     <= 1'b0;
            r_drive_q   <= 1'b0;
            r_lat_cnt   <= '0;
            r_mem_addr  <= '0;
            r_mem_re    <= 1'b0;
            r_d_out     <= '0;
            r_hit_count <= '0;
        end else begin
            r_rd_req_q <= w_rd_req;
            r_mem_re   <= w_start;
            r_drive_q  <= w_drive_nxt;
            if (w_start) begin
                r_mem_addr <= w_a_s[12:0] - BASE_ADDR[12:0];
                r_lat_cnt  <= '0;
                r_abort    <= 1'b0;
            end else begin
                if (r_state == S_FETCH) r_lat_cnt <= r_lat_cnt + 2'd1;
                if ((r_state == S_FETCH || r_state == S_WAIT) && !w_rd_req) r_abort <= 1'b1;
            end
            if (w_capture) r_d_out <= MEM_DATA;
            if (w_hit_inc) r_hit_count <= r_hit_count + 16'd1;
        end
    end

    // Raw strobes gate the output so the bus is released as soon as the Z80 ends the cycle.
    assign D_DRIVE   = r_drive_q & ~MREQ & ~RD;
    assign MEM_ADDR  = r_mem_addr;
    assign MEM_RE    = r_mem_re;
    assign D_OUT     = r_d_out;
    assign HIT_COUNT = r_hit_count;

endmodule

// File: tb/tb_z80_screen_read_responder.sv
// Randomised bench for z80_screen_read_responder: Z80 bus cycles against a transaction-level
// model of which reads are served, with what data, latency and hit count.
module tb_z80_screen_read_responder;

    localparam int SYNC    = 2;
    localparam int LAT     = 1;
    localparam int DRV_CYC = SYNC + LAT + 2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] A = '0;
    logic        MREQ = 1'b1;
    logic        RD = 1'b1;
    logic        IORQ = 1'b1;
    logic        M1 = 1'b1;
    logic [12:0] MEM_ADDR;
    logic        MEM_RE;
    logic [7:0]  MEM_DATA;
    logic [7:0]  D_OUT;
    logic        D_DRIVE;
    logic [15:0] HIT_COUNT;

    logic [7:0]  mem [8192];
    logic [7:0]  ram_q = '0;
    int          re_cnt = 0;
    logic [12:0] re_addr = '0;
    logic [15:0] exp_hits = '0;
    int          n_checks = 0;
    int          n_pass = 0;

    z80_screen_read_responder #(
        .SYNC_STAGES(SYNC),
        .BASE_ADDR(16'h4000),
        .TOP_ADDR(16'h5AFF),
        .RAM_LATENCY(LAT)
    ) dut (
        .CLK(CLK), .RESET(RESET), .A(A), .MREQ(MREQ), .RD(RD), .IORQ(IORQ), .M1(M1),
        .MEM_ADDR(MEM_ADDR), .MEM_RE(MEM_RE), .MEM_DATA(MEM_DATA),
        .D_OUT(D_OUT), .D_DRIVE(D_DRIVE), .HIT_COUNT(HIT_COUNT)
    );

    always #5 CLK = ~CLK;

    // Screen RAM with one cycle of read latency; also records every read strobe.
    always @(posedge CLK) begin
        if (MEM_RE) begin
            ram_q   <= mem[MEM_ADDR];
            re_cnt  <= re_cnt + 1;
            re_addr <= MEM_ADDR;
        end
    end
    assign MEM_DATA = ram_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // kind: 0 memory read, 1 opcode fetch, 2 memory write, 3 I/O read, 4 interrupt ack
    task automatic bus_cycle(input logic [15:0] addr, input int kind, input int hold, input int gap);
        logic        in_win = (addr >= 16'h4000) && (addr <= 16'h5AFF);
        logic        exp_re = (kind <= 1) && in_win && (hold >= 2);
        logic        served = exp_re && (hold > DRV_CYC);
        logic [15:0] off = addr - 16'h4000;
        logic [15:0] hits0 = exp_hits;
        int          re0;
        int          first = 0;
        @(negedge CLK);
        A = addr;
        case (kind)
            0: begin MREQ = 1'b0; RD = 1'b0; end
            1: begin M1 = 1'b0; MREQ = 1'b0; RD = 1'b0; end
            2: MREQ = 1'b0;
            3: begin IORQ = 1'b0; RD = 1'b0; end
            default: begin M1 = 1'b0; IORQ = 1'b0; end
        endcase
        re0 = re_cnt;
        for (int k = 1; k <= hold; k++) begin
            @(posedge CLK); #1;
            if (k == 3) A = 16'($urandom);
            if (D_DRIVE === 1'b1 && first == 0) begin
                first = k;
                check_eq("d_out", 32'(D_OUT), 32'(mem[off[12:0]]));
            end
        end
        check_eq("drive_latency", 32'(first), served ? 32'(DRV_CYC) : 32'd0);
        check_eq("hits_during", 32'(HIT_COUNT), 32'(hits0));
        @(negedge CLK);
        RD = 1'b1;
        #1;
        if (served) check_eq("drive_release", 32'(D_DRIVE), 32'd0);
        MREQ = 1'b1; IORQ = 1'b1; M1 = 1'b1;
        if (served) exp_hits = exp_hits + 16'd1;
        for (int g = 1; g <= gap; g++) begin
            @(posedge CLK); #1;
            if (served && gap > SYNC && g == SYNC) check_eq("hits_early", 32'(HIT_COUNT), 32'(hits0));
            if (g == gap && (gap > SYNC || !served)) check_eq("hits_after", 32'(HIT_COUNT), 32'(exp_hits));
        end
        check_eq("mem_re_count", 32'(re_cnt - re0), 32'(exp_re));
        if (exp_re) check_eq("mem_addr", 32'(re_addr), 32'(off[12:0]));
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hA5;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check_eq("rst_mem_re", 32'(MEM_RE), 32'd0);
        check_eq("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
        check_eq("rst_d_out", 32'(D_OUT), 32'd0);
        check_eq("rst_d_drive", 32'(D_DRIVE), 32'd0);
        check_eq("rst_hits", 32'(HIT_COUNT), 32'd0);

        bus_cycle(16'h4000, 0, 8, 4);
        check_eq("first_hit", 32'(HIT_COUNT), 32'd1);
        bus_cycle(16'h5AFF, 0, 7, 4);
        bus_cycle(16'h5B00, 0, 7, 4);
        bus_cycle(16'h3FFF, 0, 7, 4);
        bus_cycle(16'h40FE, 3, 7, 4);
        bus_cycle(16'h40FE, 4, 7, 4);
        bus_cycle(16'h4000, 1, 7, 4);
        bus_cycle(16'h4123, 2, 7, 4);
        bus_cycle(16'h4321, 0, 2, 3);

        // Reset while driving, strobes released right after the reset edge.
        @(negedge CLK);
        A = 16'h4010; MREQ = 1'b0; RD = 1'b0;
        repeat (DRV_CYC + 1) @(posedge CLK);
        #1 check_eq("pre_reset_drive", 32'(D_DRIVE), 32'd1);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK); #1;
        check_eq("reset_drive", 32'(D_DRIVE), 32'd0);
        check_eq("reset_hits", 32'(HIT_COUNT), 32'd0);
        @(negedge CLK);
        RESET = 1'b0; MREQ = 1'b1; RD = 1'b1;
        exp_hits = '0;
        repeat (4) @(posedge CLK);
        #1 check_eq("post_reset_hits", 32'(HIT_COUNT), 32'd0);
        bus_cycle(16'h4123, 0, 8, 4);

        @(negedge CLK);
        force dut.r_hit_count = 16'hFFFF;
        @(negedge CLK);
        release dut.r_hit_count;
        exp_hits = 16'hFFFF;
        #1 check_eq("preload_hits", 32'(HIT_COUNT), 32'hFFFF);
        bus_cycle(16'h4ABC, 0, 7, 4);
        check_eq("hit_wrap", 32'(HIT_COUNT), 32'd0);

        for (int n = 0; n < 10; n++) bus_cycle(16'(16'h4000 + $urandom_range(0, 16'h1AFF)), 0, 6, 2);

        for (int n = 0; n < 40; n++) begin
            logic [15:0] addr;
            int          sel = $urandom_range(0, 9);
            if (sel < 6)       addr = 16'(16'h4000 + $urandom_range(0, 16'h1AFF));
            else if (sel == 6) addr = 16'h3FFF;
            else if (sel == 7) addr = 16'h5B00;
            else if (sel == 8) addr = 16'($urandom);
            else               addr = ($urandom_range(0, 1) == 0) ? 16'h4000 : 16'h5AFF;
            bus_cycle(addr, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0,
                      ($urandom_range(0, 3) == 0) ? 2 : int'($urandom_range(6, 9)),
                      int'($urandom_range(2, 4)));
        end
        repeat (4) @(posedge CLK);
        #1 check_eq("final_hits", 32'(HIT_COUNT), 32'(exp_hits));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
